// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared state encoding and lane helpers for the write-back stage
//
// Purpose: FSM state type and the memory-lane selection/popcount helpers
// used by wb_stage. The memory-lane priority must match the memory stage.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_RETIRE   = 2'd2,
    ST_DRAIN    = 2'd3
  } wb_state_t;

  // One-hot memory lane: lane0 wins when both lanes carry a load.
  function automatic logic [1:0] mem_lane_sel(input logic [1:0] lane_v,
                                              input logic       ld0,
                                              input logic       ld1);
    mem_lane_sel = 2'b00;
    if (lane_v[0] && ld0)      mem_lane_sel = 2'b01;
    else if (lane_v[1] && ld1) mem_lane_sel = 2'b10;
  endfunction

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    popcount2 = {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/wb_lane_commit.sv
// rtl/wb_lane_commit.sv - per-lane write-enable, kill and write-data select
//
// Purpose: combinational commit decision for one retiring lane.
// Ports:
//   i_valid, i_we, i_rd, i_res : registered lane fields
//   i_is_mem, i_mem_data       : lane is the memory lane / captured load data
//   i_kill                     : lane squashed by an exception
//   o_wen, o_commit, o_wdata   : register write enable, lane retires, write data
module wb_lane_commit #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              i_valid,
  input  logic              i_we,
  input  logic [RA_W-1:0]   i_rd,
  input  logic [DATA_W-1:0] i_res,
  input  logic              i_is_mem,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_kill,
  output logic              o_wen,
  output logic              o_commit,
  output logic [DATA_W-1:0] o_wdata
);

  assign o_commit = i_valid && !i_kill;
  // x0 is hardwired zero, so writes to it are dropped here.
  assign o_wen    = o_commit && i_we && (i_rd != '0);
  assign o_wdata  = i_is_mem ? i_mem_data : i_res;

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - dual-lane write-back stage with load wait, exceptions and retire count
//
// Purpose: holds one two-lane bundle from the memory stage, waits for the
// dcache result when a lane is a load, then retires both lanes for one cycle.
// Ports:
//   clk, reset (async, active-high), flush
//   ms_valid/ms_ready handshake, lane fields lane_v, pc*, rd*, we*, res*, ld*
//   mem_ok/mem_data/mem_ale dcache load response
//   rf_we/rf_wa*/rf_wd* register-file write port, excp_v/excp_pc, retired
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ms_valid,
  output logic              ms_ready,
  input  logic [1:0]        lane_v,
  input  logic [DATA_W-1:0] pc0,
  input  logic [DATA_W-1:0] pc1,
  input  logic [RA_W-1:0]   rd0,
  input  logic [RA_W-1:0]   rd1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] res0,
  input  logic [DATA_W-1:0] res1,
  input  logic              ld0,
  input  logic              ld1,
  input  logic              mem_ok,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ale,
  output logic [1:0]        rf_we,
  output logic [RA_W-1:0]   rf_wa0,
  output logic [RA_W-1:0]   rf_wa1,
  output logic [DATA_W-1:0] rf_wd0,
  output logic [DATA_W-1:0] rf_wd1,
  output logic              excp_v,
  output logic [DATA_W-1:0] excp_pc,
  output logic [31:0]       retired
);

  wb_state_t         r_state, w_state_nxt;
  logic [1:0]        r_lane_v, r_we, r_mlane;
  logic [DATA_W-1:0] r_pc0, r_pc1, r_res0, r_res1, r_mem_data;
  logic [RA_W-1:0]   r_rd0, r_rd1;
  logic              r_mem_ale;
  logic [RA_W-1:0]   r_wa0, r_wa1;
  logic [DATA_W-1:0] r_wd0, r_wd1, r_excp_pc;
  logic [31:0]       r_retired;

  logic              w_accept, w_retire, w_fault, w_collide, w_mem_cap;
  logic [1:0]        w_in_mlane;
  logic              w_wen0, w_wen1, w_commit0, w_commit1;
  logic [DATA_W-1:0] w_wd0, w_wd1, w_fault_pc;

  assign ms_ready   = (r_state == ST_EMPTY) || (r_state == ST_RETIRE);
  // flush outranks accept, so a bundle offered under flush is not taken.
  assign w_accept   = ms_valid && ms_ready && !flush;
  assign w_in_mlane = mem_lane_sel(lane_v, ld0, ld1);
  assign w_mem_cap  = (r_state == ST_WAIT_MEM) && mem_ok && !flush;
  assign w_retire   = (r_state == ST_RETIRE) && !flush;

  // A fault on lane0 also squashes the younger lane1; a fault on lane1 leaves lane0.
  assign w_fault    = r_mem_ale && (r_mlane != 2'b00);
  assign w_fault_pc = r_mlane[0] ? r_pc0 : r_pc1;

  wb_lane_commit #(.DATA_W(DATA_W), .RA_W(RA_W)) u_lane0 (
    .i_valid(r_lane_v[0]), .i_we(r_we[0]), .i_rd(r_rd0), .i_res(r_res0),
    .i_is_mem(r_mlane[0]), .i_mem_data(r_mem_data), .i_kill(w_fault && r_mlane[0]),
    .o_wen(w_wen0), .o_commit(w_commit0), .o_wdata(w_wd0)
  );

  wb_lane_commit #(.DATA_W(DATA_W), .RA_W(RA_W)) u_lane1 (
    .i_valid(r_lane_v[1]), .i_we(r_we[1]), .i_rd(r_rd1), .i_res(r_res1),
    .i_is_mem(r_mlane[1]), .i_mem_data(r_mem_data), .i_kill(w_fault),
    .o_wen(w_wen1), .o_commit(w_commit1), .o_wdata(w_wd1)
  );

  // Lane1 is younger, so on a same-rd write its value is the architectural one.
  assign w_collide = w_wen0 && w_wen1 && (r_rd0 == r_rd1);

  assign rf_we   = w_retire ? {w_wen1, w_wen0 && !w_collide} : 2'b00;
  assign rf_wa0  = w_retire ? r_rd0 : r_wa0;
  assign rf_wa1  = w_retire ? r_rd1 : r_wa1;
  assign rf_wd0  = w_retire ? w_wd0 : r_wd0;
  assign rf_wd1  = w_retire ? w_wd1 : r_wd1;
  assign excp_v  = w_retire && w_fault;
  assign excp_pc = excp_v ? w_fault_pc : r_excp_pc;
  assign retired = r_retired;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_state_nxt = (w_in_mlane != 2'b00) ? ST_WAIT_MEM : ST_RETIRE;
      end
      ST_WAIT_MEM: begin
        if (flush)       w_state_nxt = ST_DRAIN;
        else if (mem_ok) w_state_nxt = ST_RETIRE;
      end
      ST_RETIRE: begin
        if (w_accept) w_state_nxt = (w_in_mlane != 2'b00) ? ST_WAIT_MEM : ST_RETIRE;
        else          w_state_nxt = ST_EMPTY;
      end
      ST_DRAIN: begin
        // The outstanding response is consumed and dropped; flush is moot here.
        if (mem_ok) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_lane_v   <= '0;
      r_we       <= '0;
      r_mlane    <= '0;
      r_pc0      <= '0;
      r_pc1      <= '0;
      r_rd0      <= '0;
      r_rd1      <= '0;
      r_res0     <= '0;
      r_res1     <= '0;
      r_mem_data <= '0;
      r_mem_ale  <= 1'b0;
      r_wa0      <= '0;
      r_wa1      <= '0;
      r_wd0      <= '0;
      r_wd1      <= '0;
      r_excp_pc  <= '0;
      r_retired  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_lane_v  <= lane_v;
        r_we      <= {we1, we0};
        r_mlane   <= w_in_mlane;
        r_pc0     <= pc0;
        r_pc1     <= pc1;
        r_rd0     <= rd0;
        r_rd1     <= rd1;
        r_res0    <= res0;
        r_res1    <= res1;
        r_mem_ale <= 1'b0;
      end
      if (w_mem_cap) begin
        r_mem_data <= mem_data;
        r_mem_ale  <= mem_ale;
      end
      if (w_retire) begin
        r_wa0     <= r_rd0;
        r_wa1     <= r_rd1;
        r_wd0     <= w_wd0;
        r_wd1     <= w_wd1;
        r_retired <= r_retired + {30'd0, popcount2({w_commit1, w_commit0})};
      end
      if (excp_v) r_excp_pc <= w_fault_pc;
    end
  end

endmodule
